param_register_file: RTL and testbench

//  Parametrised general-purpose register file for the MIPS datapath.

---
 rtl/param_register_file.sv | 175 +++++++++++++++++
 tb/tb_param_register_file.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// Register file with two write ports, optional bypass,
// optional registered reads and a per-register busy scoreboard.
// Port 1 has write priority over port 0. Busy set takes priority over busy clear.

// One read port: zero-register masking, write bypass and optional output register.
module param_register_file_rd_lane #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_rd_busy,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_waddr0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_waddr1,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic              i_bset,
  input  logic [ADDR_W-1:0] i_baddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rbusy
);
  logic              w_zero;
  logic              w_hit0;
  logic              w_hit1;
  logic [DATA_W-1:0] w_data;
  logic              w_busy;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rbusy;

  // Same-cycle view of the addressed register. The write enables arrive
  // already qualified, so a dropped write to r0 can never be forwarded.
  always_comb begin
    w_zero = (ZERO_REG != 0) && (i_raddr == '0);
    w_hit0 = (BYPASS != 0) && i_we0 && (i_waddr0 == i_raddr);
    w_hit1 = (BYPASS != 0) && i_we1 && (i_waddr1 == i_raddr);
    w_data = i_rd_data;
    w_busy = i_rd_busy;
    if (w_zero) begin
      w_data = '0;
      w_busy = 1'b0;
    end else begin
      if (w_hit1)      w_data = i_wdata1;
      else if (w_hit0) w_data = i_wdata0;
      // A write landing now resolves the hazard, unless a new producer
      // is claiming the same register in this cycle.
      if ((w_hit0 || w_hit1) && !(i_bset && (i_baddr == i_raddr)))
        w_busy = 1'b0;
    end
  end

  // Output register for the one-cycle-latency read mode.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
      r_rbusy <= 1'b0;
    end else begin
      r_rdata <= w_data;
      r_rbusy <= w_busy;
    end
  end

  // Outputs are held at zero for as long as reset is asserted, in either mode.
  always_comb begin
    o_rdata = '0;
    o_rbusy = 1'b0;
    if (!i_rst) begin
      if (READ_LAT != 0) begin
        o_rdata = r_rdata;
        o_rbusy = r_rbusy;
      end else begin
        o_rdata = w_data;
        o_rbusy = w_busy;
      end
    end
  end
endmodule

module param_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we0,
  input  logic [ADDR_W-1:0]        i_waddr0,
  input  logic [DATA_W-1:0]        i_wdata0,
  input  logic                     i_we1,
  input  logic [ADDR_W-1:0]        i_waddr1,
  input  logic [DATA_W-1:0]        i_wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  output logic [NUM_RD*DATA_W-1:0] o_rdata,
  output logic [NUM_RD-1:0]        o_rbusy,
  input  logic                     i_busy_set,
  input  logic [ADDR_W-1:0]        i_busy_addr
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] r_regs;
  logic [DEPTH-1:0]             r_busy;
  logic                         w_we0;
  logic                         w_we1;
  logic                         w_bset;

  // Drop writes and busy marks aimed at the hardwired zero register.
  always_comb begin
    w_we0  = i_we0      && !((ZERO_REG != 0) && (i_waddr0 == '0));
    w_we1  = i_we1      && !((ZERO_REG != 0) && (i_waddr1 == '0));
    w_bset = i_busy_set && !((ZERO_REG != 0) && (i_busy_addr == '0));
  end

  // Storage update; port 1 is applied last so it wins on an address collision.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_regs <= '0;
    end else begin
      if (w_we0) r_regs[i_waddr0] <= i_wdata0;
      if (w_we1) r_regs[i_waddr1] <= i_wdata1;
    end
  end

  // Scoreboard: set by an issuing producer, cleared by writeback; set wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_bset && (i_busy_addr == ADDR_W'(i)))
          r_busy[i] <= 1'b1;
        else if ((w_we0 && (i_waddr0 == ADDR_W'(i))) ||
                 (w_we1 && (i_waddr1 == ADDR_W'(i))))
          r_busy[i] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    assign w_raddr = i_raddr[k*ADDR_W +: ADDR_W];

    param_register_file_rd_lane #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS),
      .READ_LAT(READ_LAT)
    ) u_lane (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_raddr  (w_raddr),
      .i_rd_data(r_regs[w_raddr]),
      .i_rd_busy(r_busy[w_raddr]),
      .i_we0    (w_we0),
      .i_waddr0 (i_waddr0),
      .i_wdata0 (i_wdata0),
      .i_we1    (w_we1),
      .i_waddr1 (i_waddr1),
      .i_wdata1 (i_wdata1),
      .i_bset   (w_bset),
      .i_baddr  (i_busy_addr),
      .o_rdata  (o_rdata[k*DATA_W +: DATA_W]),
      .o_rbusy  (o_rbusy[k])
    );
  end
endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: three configurations share one stimulus stream
// and one reference model of the register contents and busy bits.
//   A: bypass, combinational read, 2 ports
//   B: no bypass, combinational read, 2 ports
//   C: bypass, registered read, 4 ports
module tb_param_register_file;
  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1, bset;
  logic [4:0]  wa0, wa1, ba;
  logic [31:0] wd0, wd1;
  logic [9:0]  raddr2;
  logic [19:0] raddr4;
  logic [63:0] a_rdata, b_rdata;
  logic [127:0] c_rdata;
  logic [1:0]  a_rbusy, b_rbusy;
  logic [3:0]  c_rbusy;

  logic [31:0] mem [32];
  bit          bq  [32];
  logic [31:0] c_pd [4];
  bit          c_pb [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_register_file #(.NUM_RD(2), .BYPASS(1), .READ_LAT(0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_we0(we0), .i_waddr0(wa0), .i_wdata0(wd0),
    .i_we1(we1), .i_waddr1(wa1), .i_wdata1(wd1), .i_raddr(raddr2),
    .o_rdata(a_rdata), .o_rbusy(a_rbusy), .i_busy_set(bset), .i_busy_addr(ba));

  param_register_file #(.NUM_RD(2), .BYPASS(0), .READ_LAT(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_we0(we0), .i_waddr0(wa0), .i_wdata0(wd0),
    .i_we1(we1), .i_waddr1(wa1), .i_wdata1(wd1), .i_raddr(raddr2),
    .o_rdata(b_rdata), .o_rbusy(b_rbusy), .i_busy_set(bset), .i_busy_addr(ba));

  param_register_file #(.NUM_RD(4), .BYPASS(1), .READ_LAT(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_we0(we0), .i_waddr0(wa0), .i_wdata0(wd0),
    .i_we1(we1), .i_waddr1(wa1), .i_wdata1(wd1), .i_raddr(raddr4),
    .o_rdata(c_rdata), .o_rbusy(c_rbusy), .i_busy_set(bset), .i_busy_addr(ba));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // What a read of addr should show this cycle, from the architectural rules.
  task automatic exp_rd(input logic [4:0] addr, input bit byp,
                        output logic [31:0] d, output bit b);
    bit hit0, hit1;
    d = mem[addr];
    b = bq[addr];
    if (rst || addr == 0) begin
      d = '0;
      b = 1'b0;
      return;
    end
    hit0 = byp && we0 && wa0 == addr;
    hit1 = byp && we1 && wa1 == addr;
    if (hit1)      d = wd1;
    else if (hit0) d = wd0;
    if ((hit0 || hit1) && !(bset && ba == addr)) b = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    logic [31:0] ed;
    bit eb;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_rd(raddr2[k*5 +: 5], 1'b1, ed, eb);
      chk($sformatf("A_rdata%0d", k), a_rdata[k*32 +: 32], ed);
      chk($sformatf("A_rbusy%0d", k), 32'(a_rbusy[k]), 32'(eb));
      exp_rd(raddr2[k*5 +: 5], 1'b0, ed, eb);
      chk($sformatf("B_rdata%0d", k), b_rdata[k*32 +: 32], ed);
      chk($sformatf("B_rbusy%0d", k), 32'(b_rbusy[k]), 32'(eb));
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("C_rdata%0d", k), c_rdata[k*32 +: 32], rst ? 32'h0 : c_pd[k]);
      chk($sformatf("C_rbusy%0d", k), 32'(c_rbusy[k]), rst ? 32'h0 : 32'(c_pb[k]));
      exp_rd(raddr4[k*5 +: 5], 1'b1, ed, eb);
      c_pd[k] = ed;
      c_pb[k] = eb;
    end
    @(posedge clk);
    if (rst) begin
      for (int a = 0; a < 32; a++) begin
        mem[a] = '0;
        bq[a]  = 1'b0;
      end
    end else begin
      for (int a = 1; a < 32; a++) begin
        if (bset && ba == a)                              bq[a] = 1'b1;
        else if ((we0 && wa0 == a) || (we1 && wa1 == a)) bq[a] = 1'b0;
      end
      if (we0 && wa0 != 0) mem[wa0] = wd0;
      if (we1 && wa1 != 0) mem[wa1] = wd1;
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; we0 = 0; we1 = 0; bset = 0;
    wa0 = 0; wa1 = 0; ba = 0; wd0 = 0; wd1 = 0;
  endtask

  function automatic logic [4:0] rnd_addr();
    logic [4:0] a;
    if ($urandom_range(0, 1) == 0) a = 5'($urandom_range(0, 7));
    else                           a = 5'($urandom_range(0, 31));
    return a;
  endfunction

  initial begin
    for (int k = 0; k < 4; k++) begin
      c_pd[k] = '0;
      c_pb[k] = 1'b0;
    end
    idle();
    raddr2 = '0;
    raddr4 = '0;
    rst = 1;
    step();
    step();
    idle();

    // Fill every register with A5A5A5A5 and mark a few busy, then reset.
    for (int i = 0; i < 16; i++) begin
      we0 = 1; wa0 = 5'(2*i);   wd0 = 32'hA5A5A5A5;
      we1 = 1; wa1 = 5'(2*i+1); wd1 = 32'hA5A5A5A5;
      raddr2 = {5'(2*i+1), 5'(2*i)};
      step();
    end
    idle();
    bset = 1; ba = 5'd3; raddr2 = {5'd3, 5'd4};
    step();
    idle(); raddr2 = {5'd3, 5'd4}; raddr4 = {5'd3, 5'd4, 5'd5, 5'd31};
    step();
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      raddr2 = {5'(4*i+1), 5'(4*i)};
      raddr4 = {5'(4*i+3), 5'(4*i+2), 5'(4*i+1), 5'(4*i)};
      step();
    end

    // Dual write to the same address: port 1 is stored.
    we0 = 1; wa0 = 5'd5; wd0 = 32'h1234;
    we1 = 1; wa1 = 5'd5; wd1 = 32'hBEEF;
    raddr2 = {5'd0, 5'd5};
    step();
    idle(); raddr2 = {5'd5, 5'd5}; raddr4 = {4{5'd5}};
    step();

    // Same-cycle write and read of r7: A forwards, B sees the old value.
    we0 = 1; wa0 = 5'd7; wd0 = 32'hCAFE; raddr2 = {5'd1, 5'd7};
    step();
    idle();
    step();

    // Zero register: write and busy mark are both dropped.
    we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; raddr2 = {5'd0, 5'd0};
    step();
    idle(); bset = 1; ba = 5'd0;
    step();
    idle();
    step();

    // Busy scoreboard on r9.
    bset = 1; ba = 5'd9; raddr2 = {5'd9, 5'd9}; raddr4 = {4{5'd9}};
    step();
    idle();
    step();
    we0 = 1; wa0 = 5'd9; wd0 = 32'h99; bset = 1; ba = 5'd9;
    step();
    idle();
    step();
    we1 = 1; wa1 = 5'd9; wd1 = 32'h999;
    step();
    idle();
    step();

    // Registered read: fresh addresses on every port each cycle, reset mid-stream.
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i == 4) rst = 1;
      we0 = 1; wa0 = 5'(i + 10); wd0 = $urandom;
      raddr4 = {5'(i + 13), 5'(i + 12), 5'(i + 11), 5'(i + 10)};
      step();
    end

    // Randomised traffic biased toward address collisions.
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 59) == 0);
      we0  = $urandom_range(0, 1) == 1; wa0 = rnd_addr(); wd0 = $urandom;
      we1  = $urandom_range(0, 2) == 0; wa1 = rnd_addr(); wd1 = $urandom;
      bset = $urandom_range(0, 2) == 0; ba  = rnd_addr();
      for (int k = 0; k < 2; k++) raddr2[k*5 +: 5] = rnd_addr();
      for (int k = 0; k < 4; k++) raddr4[k*5 +: 5] = rnd_addr();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
